// File: rtl/sync_fifo_lvl.sv
// Single-clock show-ahead FIFO with arbitrary depth, fill level and almost-full/empty flags.
// Define SYNC_FIFO_LVL_ERR_EN to build the sticky overflow/underflow error flags.
module sync_fifo_lvl #(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 128,
   parameter int AFULL_THRESH  = DEPTH - 1,
   parameter int AEMPTY_THRESH = 1,
   localparam int AW           = $clog2(DEPTH),
   localparam int LW           = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             we_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             almost_full_o,
   output logic             almost_empty_o,
   output logic [LW-1:0]    level_o,
   output logic             overflow_o,
   output logic             underflow_o,
   input  logic             err_clr_i
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             wr_acc, rd_acc;

   // Explicit wrap so non-power-of-two depths index only valid entries.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign level_o        = level_q;
   assign full_o         = (level_q == LW'(DEPTH));
   assign empty_o        = (level_q == '0);
   assign almost_full_o  = (level_q >= LW'(AFULL_THRESH));
   assign almost_empty_o = (level_q <= LW'(AEMPTY_THRESH));

   assign wr_acc = we_i & ~full_o & ~clear_i;
   assign rd_acc = re_i & ~empty_o & ~clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage has no reset; contents are only observable while non-empty.
   always_ff @(posedge clk_i) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];

`ifdef SYNC_FIFO_LVL_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Set takes priority over clear so a coinciding event is never lost.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (err_clr_i) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (we_i & full_o & ~clear_i)  ovf_d = 1'b1;
      if (re_i & empty_o & ~clear_i) udf_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr_i;
   assign overflow_o     = 1'b0;
   assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl (WIDTH=8, DEPTH=5) with a queue-based scoreboard.
module tb_sync_fifo_lvl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int LW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             clear_i = 1'b0;
   logic             we_i = 1'b0;
   logic [WIDTH-1:0] wdata_i = '0;
   logic             re_i = 1'b0;
   logic             err_clr_i = 1'b0;
   logic [WIDTH-1:0] rdata_o;
   logic             full_o, empty_o, almost_full_o, almost_empty_o;
   logic [LW-1:0]    level_o;
   logic             overflow_o, underflow_o;

   int               n_vec = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] sb[$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   sync_fifo_lvl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .we_i(we_i), .wdata_i(wdata_i),
      .re_i(re_i), .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o),
      .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
      .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
      .err_clr_i(err_clr_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      int sz;
      sz = sb.size();
      check("level", 32'(level_o), 32'(sz));
      check("empty", 32'(empty_o), 32'(sz == 0));
      check("full", 32'(full_o), 32'(sz == DEPTH));
      check("almost_full", 32'(almost_full_o), 32'(sz >= 4));
      check("almost_empty", 32'(almost_empty_o), 32'(sz <= 1));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      check("underflow", 32'(underflow_o), 32'(m_udf));
      if (sz > 0) check("rdata_head", 32'(rdata_o), 32'(sb[0]));
   endtask

   // One clock cycle: drive, score the pop, clock, update model, check outputs.
   task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re,
                        input logic clr = 1'b0, input logic eclr = 1'b0);
      bit wacc, racc;
      we_i = we; wdata_i = wd; re_i = re; clear_i = clr; err_clr_i = eclr;
      racc = re && !clr && (sb.size() > 0);
      wacc = we && !clr && (sb.size() < DEPTH);
      if (racc) check("rdata_pop", 32'(rdata_o), 32'(sb[0]));
`ifdef SYNC_FIFO_LVL_ERR_EN
      if (eclr) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (we && !clr && sb.size() == DEPTH) m_ovf = 1'b1;
      if (re && !clr && sb.size() == 0) m_udf = 1'b1;
`endif
      @(posedge clk);
      #1;
      if (clr) sb.delete();
      else begin
         if (racc) void'(sb.pop_front());
         if (wacc) sb.push_back(wd);
      end
      we_i = 1'b0; re_i = 1'b0; clear_i = 1'b0; err_clr_i = 1'b0;
      check_status();
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_status();
      rst_i = 1'b0;

      // Fill 0x11..0x55, then drain in order
      for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

      // Offset pointers, then fill/drain rounds crossing the wrap
      cycle(1'b1, 8'hA1, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) cycle(1'b1, 8'((r + 1) * 8'h10 + i), 1'b0);
         for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
      end

      // Full with simultaneous read/write; then empty with simultaneous read/write
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      cycle(1'b1, 8'h66, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h77, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);

      // Clear overrides a write
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0);
      cycle(1'b1, 8'h99, 1'b0, 1'b1);
      cycle(1'b1, 8'h88, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);

      // Error flags: overflow, hold, underflow, clear, set-wins-over-clear
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
      cycle(1'b1, 8'hEE, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hF0 + i), 1'b0);
      cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

      // Asynchronous reset between edges at level 3
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0);
      #3;
      rst_i = 1'b1;
      #1;
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_status();
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      cycle(1'b1, 8'h5A, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
